// File: rtl/fft_result_write_buffer.sv
// FFT result write buffer: Avalon-MM write slave -> FIFO -> memory master.
// Ports: clk, n_rst, clear; s_* upstream slave; m_* memory master;
//   frame_done, words_drained, addr_error status.
//   Optional: FFT_WBUF_ADDR_CHECK_EN enables address-sequence checking.
module fft_result_write_buffer #(
  parameter int ADDRESSWIDTH = 32,
  parameter int DATAWIDTH    = 32,
  parameter int DEPTH        = 8,
  parameter int FRAME_WORDS  = 512
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          clear,
  input  logic [ADDRESSWIDTH-1:0]       s_address,
  input  logic                          s_write,
  input  logic [DATAWIDTH-1:0]          s_writedata,
  output logic                          s_waitrequest,
  output logic [ADDRESSWIDTH-1:0]       m_address,
  output logic                          m_write,
  output logic [DATAWIDTH-1:0]          m_writedata,
  input  logic                          m_waitrequest,
  output logic                          frame_done,
  output logic [$clog2(FRAME_WORDS):0]  words_drained,
  output logic                          addr_error
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = PW + 1;
  localparam int CW   = $clog2(FRAME_WORDS) + 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic [CW-1:0]   FRAME_MAX = CW'(FRAME_WORDS);
  localparam logic [CNTW-1:0] FULL_CNT  = CNTW'(DEPTH);

  logic [ADDRESSWIDTH-1:0] addr_q [DEPTH];
  logic [DATAWIDTH-1:0]    data_q [DEPTH];

  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CNTW-1:0] count;
  logic [CNTW-1:0] count_nxt;
  logic            full_q;
  logic [1:0]      state;
  logic            push;
  logic            pop;
  logic            last_pop;

  assign s_waitrequest = full_q | (state == DONE) | clear;
  assign push          = s_write & ~s_waitrequest;
  assign m_write       = (count != '0);
  assign pop           = m_write & ~m_waitrequest;
  assign m_address     = addr_q[rd_ptr];
  assign m_writedata   = data_q[rd_ptr];
  assign frame_done    = (state == DONE);
  assign last_pop      = pop &&
    (words_drained == FRAME_MAX - 1'b1);

  always_comb begin
    count_nxt = count;
    unique case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Storage is reset so the head outputs read zero out of reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full_q <= 1'b0;
    end else begin
      if (push) begin
        addr_q[wr_ptr] <= s_address;
        data_q[wr_ptr] <= s_writedata;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count  <= count_nxt;
      full_q <= (count_nxt == FULL_CNT);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      words_drained <= '0;
    end else if (clear) begin
      state         <= IDLE;
      words_drained <= '0;
    end else begin
      if (pop && (words_drained != FRAME_MAX)) begin
        words_drained <= words_drained + 1'b1;
      end
      unique case (1'b1)
        (state == IDLE):   if (push) state <= ACTIVE;
        (state == ACTIVE): if (last_pop) state <= DONE;
        default:           state <= state;
      endcase
    end
  end

`ifdef FFT_WBUF_ADDR_CHECK_EN
  localparam logic [ADDRESSWIDTH-1:0] STEP =
    ADDRESSWIDTH'(DATAWIDTH / 8);

  logic [ADDRESSWIDTH-1:0] last_addr;
  logic                    have_addr;
  logic                    err_q;

  // First push of a frame only seeds the reference address.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      last_addr <= '0;
      have_addr <= 1'b0;
      err_q     <= 1'b0;
    end else if (clear) begin
      last_addr <= '0;
      have_addr <= 1'b0;
      err_q     <= 1'b0;
    end else if (push) begin
      if (have_addr && (s_address != last_addr + STEP)) begin
        err_q <= 1'b1;
      end
      last_addr <= s_address;
      have_addr <= 1'b1;
    end
  end

  assign addr_error = err_q;
`else
  assign addr_error = 1'b0;
`endif

endmodule
